imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage.
- Accepts a full 32-bit instruction over a valid/ready handshake and produces an XLEN-wide extended immediate through a registered 2-entry output buffer.
- Format comes either from the control unit (ImmSrc) or from the block's own opcode decoder.
- Adds over the combinational extender: XLEN=64 support, CSR-zimm and shift-amount formats, sideband tag pass-through, back-pressure and flush.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- AUTO_DECODE, 0, 0: format taken from imm_src port; 1: format derived from instr opcode/funct3, imm_src ignored.
- TAG_W, 8, width of sideband tag carried alongside each instruction (e.g. PC low bits / slot id).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush; empties buffer.
- in_valid  input  1  instr/imm_src/in_tag valid.
- in_ready  output  1  buffer can accept; transfer when in_valid & in_ready.
- instr  input  32  full instruction word.
- imm_src  input  3  format select (used when AUTO_DECODE=0).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.
- imm  output  XLEN  extended immediate of head entry.
- out_src  output  3  format code actually applied to head entry.
- out_tag  output  TAG_W  tag of head entry.

Behaviour:
- Formats (3-bit code):
  - 000 I = sext(instr[31:20])
  - 001 S = sext({instr[31:25], instr[11:7]})
  - 010 B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 011 J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 100 U = sext({instr[31:12], 12'b0})
  - 101 Z = zext(instr[19:15])
  - 110 SH = zext(instr[25:20]) if XLEN=64, else zext(instr[24:20])
  - 111 invalid = 0
- All sign extension is from the top immediate bit (instr[31]) up to XLEN.
- AUTO_DECODE opcode map:
  - 0000011, 1100111 -> I.
  - 0010011 -> SH if funct3 is 001 or 101, else I.
  - 0011011 (XLEN=64 only) -> SH with zext(instr[24:20]) if funct3 is 001 or 101, else I. When XLEN=32 this opcode -> 111.
  - 1110011 -> Z if funct3[2]=1, else I.
  - 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110111, 0010111 -> U.
  - Any other opcode -> 111.
- Datapath: immediate computed combinationally at input and written into a 2-entry FIFO {imm, src, tag}. The head entry drives the outputs directly.
- Occupancy count states: EMPTY (0), ONE (1), FULL (2).
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE (head advances, new entry becomes head).
  - FULL: pop -> ONE; no push is possible.
- in_ready = (count != 2), derived from registered state only; never depends on out_ready in the same cycle.
- out_valid = (count != 0).
- Latency: accepted in cycle N -> visible on outputs in cycle N+1 if the buffer was empty. Order is strictly FIFO.
- Read/write pointers are 1 bit each and wrap 1 -> 0.
- flush (synchronous, highest priority): count <- 0 and pointers <- 0. A push or pop in the flush cycle is discarded. Next cycle out_valid=0 and in_ready=1.
- Reset (async, any time, including mid-transfer): count=0, pointers=0, storage cleared.
  - Outputs during and after reset: out_valid=0, imm=0, out_src=000, out_tag=0, in_ready=1.
  - Contents in flight at reset are lost.
- out_valid must not drop and head contents must not change while out_valid & ~out_ready, except on flush or reset.

Optional Feature:
- Macro: IMMGEN_ERR_EN.
- Defined: extra output port err (1 bit), stored per entry and aligned with the head entry.
  - err=1 when the applied format is 111 (imm_src=111, or an unmapped opcode under AUTO_DECODE).
  - err=1 when AUTO_DECODE=0 and imm_src=110 with XLEN=32 while instr[25]=1 (illegal RV32 shamt).
  - Entry still flows; imm=0 for format 111.
  - Reset value 0.
- Not defined: no err port; behaviour otherwise identical.

Test Plan:
- AUTO_DECODE=1, XLEN=32, instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, out_src=000.
- AUTO_DECODE=1, instr=0xFE112E23 (sw x1,-4(x2)) -> imm=0xFFFFFFFC, out_src=001; instr=0x300FD073 (csrrwi) -> imm=0x0000001F, out_src=101.
- XLEN=64, AUTO_DECODE=0, imm_src=011, instr=0xFF9FF06F (jal x0,-8) -> imm=0xFFFFFFFFFFFFFFF8, tag preserved.
- out_ready=0, present three instructions with tags 1,2,3 -> first two accepted, in_ready=0 with tag 3 held. Raise out_ready -> outputs tags 1,2,3 in order, in_ready=1 after first pop.
- Buffer FULL, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, new instruction not stored.
- rst_n low for 1 cycle mid-stream with count=1 -> out_valid=0, imm=0 immediately (async). After release, first new push appears after 1 cycle.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with a 2-entry output buffer.
// Optional IMMGEN_ERR_EN adds a per-entry err output for illegal formats.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int TAG_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       out_src,
    output logic [TAG_W-1:0] out_tag
`ifdef IMMGEN_ERR_EN
    , output logic           err
`endif
);
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [2:0]      dec_src;
    logic [2:0]      src;
    logic            sh5;
    logic [XLEN-1:0] imm_w;
    logic            push;
    logic            pop;
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] imm_q [2];
    logic [XLEN-1:0] imm_d [2];
    logic [2:0]      src_q [2];
    logic [2:0]      src_d [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [TAG_W-1:0] tag_d [2];
`ifdef IMMGEN_ERR_EN
    logic            err_w;
    logic            err_q [2];
    logic            err_d [2];
`endif

    assign opc = instr[6:0];
    assign f3  = instr[14:12];

    always_comb begin
        dec_src = 3'b111;
        case (opc)
            7'b0000011, 7'b1100111: dec_src = 3'b000;
            7'b0010011:             dec_src = (f3[1:0] == 2'b01) ? 3'b110 : 3'b000;
            7'b0011011:             dec_src = (XLEN != 64) ? 3'b111 : (f3[1:0] == 2'b01) ? 3'b110 : 3'b000;
            7'b1110011:             dec_src = f3[2] ? 3'b101 : 3'b000;
            7'b0100011:             dec_src = 3'b001;
            7'b1100011:             dec_src = 3'b010;
            7'b1101111:             dec_src = 3'b011;
            7'b0110111, 7'b0010111: dec_src = 3'b100;
            default:                dec_src = 3'b111;
        endcase
    end

    assign src = (AUTO_DECODE != 0) ? dec_src : imm_src;
    // RV64 word shifts (OP-IMM-32) only carry a 5-bit shamt
    assign sh5 = (XLEN == 32) || ((AUTO_DECODE != 0) && opc == 7'b0011011);

    always_comb begin
        imm_w = '0;
        case (src)
            3'b000:  imm_w = XLEN'($signed(instr[31:20]));
            3'b001:  imm_w = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010:  imm_w = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            3'b011:  imm_w = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            3'b100:  imm_w = XLEN'($signed({instr[31:12], 12'b0}));
            3'b101:  imm_w = XLEN'(instr[19:15]);
            3'b110:  imm_w = sh5 ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
            default: imm_w = '0;
        endcase
    end

`ifdef IMMGEN_ERR_EN
    assign err_w = (src == 3'b111) ||
                   ((AUTO_DECODE == 0) && (XLEN == 32) && imm_src == 3'b110 && instr[25]);
`endif

    assign in_ready  = count_q != 2'd2;
    assign out_valid = count_q != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        imm_d    = imm_q;
        src_d    = src_q;
        tag_d    = tag_q;
`ifdef IMMGEN_ERR_EN
        err_d    = err_q;
`endif
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                imm_d[wr_ptr_q] = imm_w;
                src_d[wr_ptr_q] = src;
                tag_d[wr_ptr_q] = in_tag;
`ifdef IMMGEN_ERR_EN
                err_d[wr_ptr_q] = err_w;
`endif
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            imm_q    <= '{default: '0};
            src_q    <= '{default: '0};
            tag_q    <= '{default: '0};
`ifdef IMMGEN_ERR_EN
            err_q    <= '{default: '0};
`endif
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            imm_q    <= imm_d;
            src_q    <= src_d;
            tag_q    <= tag_d;
`ifdef IMMGEN_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign imm     = imm_q[rd_ptr_q];
    assign out_src = src_q[rd_ptr_q];
    assign out_tag = tag_q[rd_ptr_q];
`ifdef IMMGEN_ERR_EN
    assign err     = err_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe (RV32 auto-decode and RV64 manual-select instances).
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        iv = 1'b0, ir, ov, ordy = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  src = '0, osrc;
    logic [7:0]  tag = '0, otag;
    logic [31:0] imm32;
    logic        iv64 = 1'b0, ir64, ov64;
    logic [31:0] instr64 = '0;
    logic [2:0]  src64 = '0, osrc64;
    logic [7:0]  tag64 = '0, otag64;
    logic [63:0] imm64;
    int          n_chk = 0;
    int          n_fail = 0;
`ifdef IMMGEN_ERR_EN
    logic        err32, err64;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv), .in_ready(ir),
        .instr(instr), .imm_src(src), .in_tag(tag), .out_valid(ov), .out_ready(ordy),
        .imm(imm32), .out_src(osrc), .out_tag(otag)
`ifdef IMMGEN_ERR_EN
        , .err(err32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(0), .TAG_W(8)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv64), .in_ready(ir64),
        .instr(instr64), .imm_src(src64), .in_tag(tag64), .out_valid(ov64), .out_ready(1'b1),
        .imm(imm64), .out_src(osrc64), .out_tag(otag64)
`ifdef IMMGEN_ERR_EN
        , .err(err64)
`endif
    );

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", t, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [7:0] t);
        iv = 1'b1;
        instr = i;
        tag = t;
    endtask

    initial begin
        step();
        step();
        chk("rst_out_valid", ov, 0);
        chk("rst_in_ready", ir, 1);
        chk("rst_imm", imm32, 0);
        chk("rst_src", osrc, 0);
        chk("rst_tag", otag, 0);
        chk("rst_imm64", imm64, 0);
        rst_n = 1'b1;
        step();
        // streaming through the RV32 auto-decode instance
        ordy = 1'b1;
        drive(32'hFFF00093, 8'h11);
        step();
        chk("addi_valid", ov, 1);
        chk("addi_imm", imm32, 32'hFFFFFFFF);
        chk("addi_src", osrc, 3'b000);
        chk("addi_tag", otag, 8'h11);
`ifdef IMMGEN_ERR_EN
        chk("addi_err", err32, 0);
`endif
        drive(32'hFE112E23, 8'h22);
        step();
        chk("sw_imm", imm32, 32'hFFFFFFFC);
        chk("sw_src", osrc, 3'b001);
        chk("sw_tag", otag, 8'h22);
        drive(32'h300FD073, 8'h23);
        step();
        chk("csrrwi_imm", imm32, 32'h0000001F);
        chk("csrrwi_src", osrc, 3'b101);
        drive(32'h00301093, 8'h24);
        step();
        chk("slli_imm", imm32, 32'h3);
        chk("slli_src", osrc, 3'b110);
        drive(32'h12345037, 8'h25);
        step();
        chk("lui_imm", imm32, 32'h12345000);
        chk("lui_src", osrc, 3'b100);
        drive(32'hFE000EE3, 8'h26);
        step();
        chk("beq_imm", imm32, 32'hFFFFFFFC);
        chk("beq_src", osrc, 3'b010);
        drive(32'hFF9FF06F, 8'h27);
        step();
        chk("jal32_imm", imm32, 32'hFFFFFFF8);
        chk("jal32_src", osrc, 3'b011);
        drive(32'h00000033, 8'h28);
        step();
        chk("rtype_imm", imm32, 0);
        chk("rtype_src", osrc, 3'b111);
`ifdef IMMGEN_ERR_EN
        chk("rtype_err", err32, 1);
`endif
        drive(32'hFFF0009B, 8'h29);
        step();
        chk("op32_on_rv32_src", osrc, 3'b111);
        iv = 1'b0;
        step();
        chk("drain_valid", ov, 0);
        // RV64 manual-select instance
        iv64 = 1'b1; src64 = 3'b011; instr64 = 32'hFF9FF06F; tag64 = 8'h5A;
        step();
        chk("jal64_imm", imm64, 64'hFFFFFFFFFFFFFFF8);
        chk("jal64_src", osrc64, 3'b011);
        chk("jal64_tag", otag64, 8'h5A);
        src64 = 3'b110; instr64 = 32'h03F01093; tag64 = 8'h5B;
        step();
        chk("sh64_imm", imm64, 64'h3F);
        chk("sh64_tag", otag64, 8'h5B);
        src64 = 3'b100; instr64 = 32'h80000037; tag64 = 8'h5C;
        step();
        chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("in_ready64", ir64, 1);
        iv64 = 1'b0;
        // back-pressure: three offered, two held
        ordy = 1'b0;
        drive(32'h00100093, 8'd1);
        step();
        chk("bp1_valid", ov, 1);
        chk("bp1_tag", otag, 1);
        chk("bp1_ready", ir, 1);
        drive(32'h00200093, 8'd2);
        step();
        chk("bp2_ready", ir, 0);
        chk("bp2_tag", otag, 1);
        drive(32'h00300093, 8'd3);
        step();
        chk("bp3_ready", ir, 0);
        chk("bp3_valid", ov, 1);
        chk("bp3_tag", otag, 1);
        chk("bp3_imm", imm32, 1);
        ordy = 1'b1;
        step();
        chk("pop1_tag", otag, 2);
        chk("pop1_ready", ir, 1);
        step();
        chk("pop2_tag", otag, 3);
        chk("pop2_imm", imm32, 3);
        iv = 1'b0;
        step();
        chk("pop3_valid", ov, 0);
        // flush while full, with a concurrent push
        ordy = 1'b0;
        drive(32'h00400093, 8'd4);
        step();
        drive(32'h00500093, 8'd5);
        step();
        chk("full_ready", ir, 0);
        flush = 1'b1;
        drive(32'h00600093, 8'd6);
        step();
        flush = 1'b0;
        iv = 1'b0;
        chk("flush_valid", ov, 0);
        chk("flush_ready", ir, 1);
        step();
        chk("flush_nostore", ov, 0);
        // asynchronous reset mid-stream
        drive(32'h00700093, 8'd7);
        step();
        iv = 1'b0;
        chk("pre_rst_valid", ov, 1);
        chk("pre_rst_imm", imm32, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", ov, 0);
        chk("async_rst_imm", imm32, 0);
        chk("async_rst_tag", otag, 0);
        step();
        rst_n = 1'b1;
        ordy = 1'b1;
        drive(32'h00800093, 8'd8);
        step();
        iv = 1'b0;
        chk("post_rst_valid", ov, 1);
        chk("post_rst_tag", otag, 8);
        chk("post_rst_imm", imm32, 8);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
